baud_gen_frac: RTL and testbench

- Parametrised fractional baud/oversample tick generator for the APB UART. Successor to the fixed integer-divisor baud generator.
- Produces a one-cycle sample_tick at baud×SAMPLE and a bit_tick every SAMPLE sample ticks.
- Divisor comes from one of four preset rates or from a runtime integer.fraction value. Divisor changes are applied glitch-free at interval boundaries.
- Sits between the APB UART register block (divisor/config) and the TX/RX shift FSMs (tick consumers).

---
 rtl/baud_gen_frac.sv | 165 ++++++++++++++++
 tb/tb_baud_gen_frac.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/baud_gen_frac.sv
// Fractional baud/oversample tick generator: sample_tick at baud*SAMPLE, bit_tick every SAMPLE ticks.
// Optional square-wave baud_clk output is built only when BAUD_GEN_CLK_OUT_EN is defined.
`timescale 1ns/1ps
module baud_gen_frac #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned SAMPLE   = 16,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned FRAC_W   = 4
) (
  input  logic              SysClk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic [1:0]        baud_selector,
  input  logic              sel_custom,
  input  logic [DIV_W-1:0]  custom_div_int,
  input  logic [FRAC_W-1:0] custom_div_frac,
  input  logic              div_update,
  output logic              div_pending,
  output logic              cfg_err,
  output logic              sample_tick,
  output logic              bit_tick,
  output logic              baud_clk
);

  localparam int unsigned DW   = DIV_W + FRAC_W;
  localparam int unsigned PH_W = $clog2(SAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SAMPLE - 1);

  typedef logic [DW-1:0] div_t;

  // Round-to-nearest INT.FRAC divisor for a given baud rate.
  function automatic div_t preset_div(input longint unsigned baud);
    longint unsigned den;
    longint unsigned num;
    den = baud * 64'(SAMPLE);
    num = 64'(CLK_FREQ) * (64'd1 << FRAC_W) + den / 64'd2;
    return div_t'(num / den);
  endfunction

  localparam div_t P4800   = preset_div(64'd4800);
  localparam div_t P9600   = preset_div(64'd9600);
  localparam div_t P57600  = preset_div(64'd57600);
  localparam div_t P115200 = preset_div(64'd115200);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  div_t              act_q, act_d;
  div_t              pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              err_q, err_d;
  logic              stick_q, stick_d;
  logic              btick_q, btick_d;

  div_t              sel_div;
  div_t              pend_load;
  logic              pend_zero;
  logic [FRAC_W:0]   sum;
  logic [DIV_W:0]    last;
  logic              at_end;
  logic              apply;

  always_comb begin
    case (baud_selector)
      2'd0:    sel_div = P4800;
      2'd1:    sel_div = P9600;
      2'd2:    sel_div = P57600;
      default: sel_div = P115200;
    endcase
    if (sel_custom) sel_div = {custom_div_int, custom_div_frac};
  end

  assign pend_zero = (pend_q[DW-1:FRAC_W] == '0);
  assign pend_load = pend_zero ? {DIV_W'(1), pend_q[FRAC_W-1:0]} : pend_q;

  // Interval end compares against L-1; >= keeps a shrunken divisor from overrunning the counter.
  assign sum    = {1'b0, acc_q} + {1'b0, act_q[FRAC_W-1:0]};
  assign last   = {1'b0, act_q[DW-1:FRAC_W]} + (DIV_W+1)'(sum[FRAC_W]) - (DIV_W+1)'(1);
  assign at_end = ({1'b0, cnt_q} >= last);
  assign apply  = pend_vld_q & (sync_clr | ~en | at_end);

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    phase_d    = phase_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = err_q;
    stick_d    = 1'b0;
    btick_d    = 1'b0;
    if (sync_clr) begin
      cnt_d   = '0;
      acc_d   = '0;
      phase_d = '0;
    end else if (en) begin
      if (at_end) begin
        cnt_d   = '0;
        acc_d   = sum[FRAC_W-1:0];
        stick_d = 1'b1;
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          btick_d = 1'b1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
    if (apply) begin
      act_d      = pend_load;
      pend_vld_d = 1'b0;
      if (pend_zero) err_d = 1'b1;
    end
    // A fresh request always wins over one being retired on the same edge.
    if (div_update) begin
      pend_d     = sel_div;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge SysClk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      phase_q    <= '0;
      act_q      <= P9600;
      pend_q     <= P9600;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      stick_q    <= 1'b0;
      btick_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      stick_q    <= stick_d;
      btick_q    <= btick_d;
    end
  end

`ifdef BAUD_GEN_CLK_OUT_EN
  logic bclk_q, bclk_d;
  assign bclk_d = bclk_q ^ stick_d;
  always_ff @(posedge SysClk or posedge rst) begin
    if (rst) bclk_q <= 1'b0;
    else     bclk_q <= bclk_d;
  end
  assign baud_clk = bclk_q;
`else
  assign baud_clk = 1'b0;
`endif

  assign div_pending = pend_vld_q;
  assign cfg_err     = err_q;
  assign sample_tick = stick_q;
  assign bit_tick    = btick_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: directed steps plus randomized traffic against a
// cumulative-time tick model (tick n of a divisor segment lands at n*INT + floor((acc0+n*FRAC)/16)).
`timescale 1ns/1ps
module tb_baud_gen_frac;
  localparam int SAMPLE = 16;
  localparam int FSCALE = 16;

  logic        SysClk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        sync_clr = 1'b0;
  logic [1:0]  baud_selector = 2'd1;
  logic        sel_custom = 1'b0;
  logic [15:0] custom_div_int = '0;
  logic [3:0]  custom_div_frac = '0;
  logic        div_update = 1'b0;
  logic        div_pending, cfg_err, sample_tick, bit_tick, baud_clk;

  baud_gen_frac dut (
    .SysClk(SysClk), .rst(rst), .en(en), .sync_clr(sync_clr),
    .baud_selector(baud_selector), .sel_custom(sel_custom),
    .custom_div_int(custom_div_int), .custom_div_frac(custom_div_frac),
    .div_update(div_update), .div_pending(div_pending), .cfg_err(cfg_err),
    .sample_tick(sample_tick), .bit_tick(bit_tick), .baud_clk(baud_clk)
  );

  always #5 SysClk = ~SysClk;

  int vectors = 0;
  int miscompares = 0;

  int m_int, m_frac, m_acc0, m_n, m_e, m_tot, m_pint, m_pfrac;
  bit m_pend, m_err, m_bclk, m_last_tick;
  int cyc, first_st, first_bt, second_bt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int preset_code(input int sel);
    case (sel)
      0:       return 10417;
      1:       return 5208;
      2:       return 868;
      default: return 434;
    endcase
  endfunction

  function automatic int tpos(input int n);
    return n * m_int + (m_acc0 + n * m_frac) / FSCALE;
  endfunction

  task automatic model_reset();
    m_int = 325; m_frac = 8; m_acc0 = 0; m_n = 0; m_e = 0; m_tot = 0;
    m_pend = 0; m_err = 0; m_bclk = 0; m_last_tick = 0; m_pint = 0; m_pfrac = 0;
    cyc = 0; first_st = -1; first_bt = -1; second_bt = -1;
  endtask

  task automatic step();
    int c, a, code;
    bit exp_t, exp_b;
    exp_t = 0; exp_b = 0;
    if (sync_clr) begin
      m_acc0 = 0; m_n = 0; m_e = 0; m_tot = 0;
    end else if (en) begin
      m_e++;
      if (m_e == tpos(m_n + 1)) begin
        exp_t = 1; m_n++; m_tot++;
        if (m_tot % SAMPLE == 0) exp_b = 1;
      end
    end
    if (m_pend && (sync_clr || !en || exp_t)) begin
      c = m_e - tpos(m_n);
      a = (m_acc0 + m_n * m_frac) % FSCALE;
      m_int = (m_pint == 0) ? 1 : m_pint;
      m_frac = m_pfrac;
      if (m_pint == 0) m_err = 1;
      m_acc0 = a; m_n = 0; m_e = c; m_pend = 0;
    end
    if (div_update) begin
      code = sel_custom ? int'(custom_div_int) * FSCALE + int'(custom_div_frac)
                        : preset_code(int'(baud_selector));
      m_pint = code / FSCALE; m_pfrac = code % FSCALE; m_pend = 1;
    end
    if (exp_t) m_bclk = !m_bclk;
    @(posedge SysClk); #1;
    cyc++;
    m_last_tick = exp_t;
    chk("sample_tick", sample_tick, exp_t);
    chk("bit_tick", bit_tick, exp_b);
    chk("div_pending", div_pending, m_pend);
    chk("cfg_err", cfg_err, m_err);
`ifdef BAUD_GEN_CLK_OUT_EN
    chk("baud_clk", baud_clk, m_bclk);
`else
    chk("baud_clk", baud_clk, 1'b0);
`endif
    if (sample_tick === 1'b1 && first_st < 0) first_st = cyc;
    if (bit_tick === 1'b1) begin
      if (first_bt < 0) first_bt = cyc;
      else if (second_bt < 0) second_bt = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_tick(input int max);
    int k;
    k = 0;
    do begin step(); k++; end while (!m_last_tick && k < max);
    vectors++;
    assert (m_last_tick) else begin
      miscompares++;
      $error("FAIL tick_timeout: observed no tick within %0d cycles expected a tick", max);
    end
  endtask

  task automatic wait_pend_clear(input int max);
    int k;
    k = 0;
    while (m_pend && k < max) begin step(); k++; end
    vectors++;
    assert (!m_pend) else begin
      miscompares++;
      $error("FAIL pending_timeout: observed pending after %0d cycles expected cleared", max);
    end
  endtask

  task automatic pulse_update();
    div_update = 1'b1; step(); div_update = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_sample_tick", sample_tick, 1'b0);
    chk("rst_bit_tick", bit_tick, 1'b0);
    chk("rst_baud_clk", baud_clk, 1'b0);
    chk("rst_div_pending", div_pending, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    repeat (3) @(posedge SysClk);
    @(negedge SysClk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Default 325.8 divisor: first tick after 325 edges, bit ticks every 5208.
    en = 1'b1;
    run(2 * 5208 + 5);
    chk("first_sample_tick_cycle", first_st, 325);
    chk("first_bit_tick_cycle", first_bt, 5208);
    chk("second_bit_tick_cycle", second_bt, 10416);

    baud_selector = 2'd3; sel_custom = 1'b0;
    pulse_update();
    wait_pend_clear(400);
    run(3 * 434);

    sel_custom = 1'b1; custom_div_int = 16'd10; custom_div_frac = 4'd0;
    wait_tick(40);
    pulse_update();
    step();
    custom_div_int = 16'd20;
    pulse_update();
    wait_pend_clear(40);
    run(200);

    custom_div_int = 16'd0; custom_div_frac = 4'd0;
    pulse_update();
    wait_pend_clear(40);
    run(20);
    custom_div_int = 16'd6; custom_div_frac = 4'd8;
    pulse_update();
    wait_pend_clear(10);
    run(60);

    // sync_clr with counter=100, phase=7 under the reset divisor.
    do_reset();
    en = 1'b1;
    run(2378);
    sync_clr = 1'b1; step(); sync_clr = 1'b0;
    run(5208 + 5);

    run(100);
    en = 1'b0; run(50);
    en = 1'b1; run(400);

    // Update taken on a disabled edge right after a tick.
    wait_tick(400);
    en = 1'b0; sel_custom = 1'b1; custom_div_int = 16'd7; custom_div_frac = 4'd3;
    pulse_update();
    step();
    en = 1'b1;
    run(100);

    for (int i = 0; i < 3000; i++) begin
      div_update = ($urandom_range(0, 149) == 0);
      sel_custom = 1'($urandom_range(0, 1));
      baud_selector = 2'($urandom_range(0, 3));
      custom_div_int = 16'($urandom_range(0, 9));
      custom_div_frac = 4'($urandom_range(0, 15));
      en = (m_pend || div_update) ? 1'b1 : ($urandom_range(0, 7) != 0);
      sync_clr = ($urandom_range(0, 199) == 0);
      step();
    end
    div_update = 1'b0; sync_clr = 1'b0; en = 1'b1;
    wait_pend_clear(700);

    sel_custom = 1'b1; custom_div_int = 16'd0; custom_div_frac = 4'd0;
    pulse_update();
    wait_pend_clear(700);
    custom_div_int = 16'd1;
    div_update = 1'b1;
    run(3);
    div_update = 1'b0;
    do_reset();
    en = 1'b1;
    run(330);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
